// File: rtl/arith_mult_cst_csd.sv
// Pipelined multiply by a compile-time constant in signed-power-of-two form.
// Define ARITH_MULT_CST_CSD_DATA_RST_EN to reset every data pipeline register to 0.

// Data pipeline register; resettable only when the data-reset build is selected.
module arith_mult_cst_csd_dreg #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         s_rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] data_q;

`ifdef ARITH_MULT_CST_CSD_DATA_RST_EN
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) data_q <= '0;
        else          data_q <= d_i;
    end
`else
    logic unused_rst;
    assign unused_rst = s_rst_n;

    always_ff @(posedge clk) begin
        data_q <= d_i;
    end
`endif

    assign q_o = data_q;
endmodule

// One adder-tree level: pairs operands, an odd trailing operand passes through.
module arith_mult_cst_csd_lvl #(
    parameter int unsigned Z_W  = 128,
    parameter int unsigned N    = 3,
    parameter int unsigned N_IN = 3,
    parameter bit          REG  = 1'b1
) (
    input  logic                  clk,
    input  logic                  s_rst_n,
    input  logic [N-1:0][Z_W-1:0] op_i,
    output logic [N-1:0][Z_W-1:0] sum_o
);
    logic [N-1:0][Z_W-1:0] sum_c;
    logic                  unused_ops;

    // Entries beyond the active operand count are zero and fold away.
    assign unused_ops = ^op_i;

    for (genvar j = 0; j < N; j++) begin : g_node
        if (2 * j + 1 < N_IN) begin : g_add
            assign sum_c[j] = op_i[2*j] + op_i[2*j+1];
        end else if (2 * j < N_IN) begin : g_pass
            assign sum_c[j] = op_i[2*j];
        end else begin : g_zero
            assign sum_c[j] = '0;
        end
    end

    if (REG) begin : g_reg
        arith_mult_cst_csd_dreg #(.W(N * Z_W)) u_reg (
            .clk     (clk),
            .s_rst_n (s_rst_n),
            .d_i     (sum_c),
            .q_o     (sum_o)
        );
    end else begin : g_comb
        logic unused_clk;
        assign unused_clk = clk ^ s_rst_n;
        assign sum_o      = sum_c;
    end
endmodule

module arith_mult_cst_csd #(
    parameter int unsigned              IN_W            = 64,
    parameter int unsigned              CST_W           = 64,
    parameter int unsigned              TERM_NB         = 3,
    parameter logic [TERM_NB-1:0][31:0] TERM_POW        = {32'd64, 32'd32, 32'd0},
    parameter logic [TERM_NB-1:0]       TERM_SGN        = 3'b010,
    parameter logic [CST_W-1:0]         CST             = 64'hFFFF_FFFF_0000_0001,
    parameter bit                       IN_PIPE         = 1'b1,
    parameter int unsigned              ADD_PIPE_PERIOD = 1,
    parameter int unsigned              SIDE_W          = 0,
    parameter logic [1:0]               RST_SIDE        = 2'b00
) (
    input  logic                                 clk,
    input  logic                                 s_rst_n,
    input  logic [IN_W-1:0]                      a,
    input  logic                                 in_avail,
    input  logic [(SIDE_W > 0 ? SIDE_W : 1)-1:0] in_side,
    output logic [IN_W+CST_W-1:0]                z,
    output logic                                 out_avail,
    output logic [(SIDE_W > 0 ? SIDE_W : 1)-1:0] out_side
);
    localparam int unsigned TERM_NB_MAX = 8;
    localparam int unsigned Z_W         = IN_W + CST_W;
    localparam int unsigned SIDE_WI     = (SIDE_W > 0) ? SIDE_W : 1;
    localparam int unsigned SUM_W       = CST_W + 8;
    localparam int unsigned P_SAFE      = (ADD_PIPE_PERIOD == 0) ? 1 : ADD_PIPE_PERIOD;
    localparam int unsigned LVL_NB      = $clog2(TERM_NB);
    localparam int unsigned STG_NB      = (LVL_NB == 0) ? 1 : (LVL_NB + P_SAFE - 1) / P_SAFE;
    localparam int unsigned LAT         = 32'(IN_PIPE) + STG_NB;

    // Exact signed sum of the terms, wide enough for eight terms of 2**CST_W.
    function automatic logic signed [SUM_W-1:0] term_sum();
        logic signed [SUM_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < int'(TERM_NB); i++) begin
            if (TERM_SGN[i]) acc = acc - (SUM_W'(1) << TERM_POW[i]);
            else             acc = acc + (SUM_W'(1) << TERM_POW[i]);
        end
        return acc;
    endfunction

    function automatic bit pow_ok();
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < int'(TERM_NB); i++) begin
            if (TERM_POW[i] > CST_W) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic int unsigned nodes(input int unsigned l);
        return (TERM_NB + (32'd1 << l) - 32'd1) >> l;
    endfunction

    function automatic bit lvl_reg(input int unsigned l);
        return ((l % P_SAFE) == 0) || (l == LVL_NB);
    endfunction

    localparam logic signed [SUM_W-1:0] CST_SUM = term_sum();
    localparam logic signed [SUM_W-1:0] CST_EXT = SUM_W'(CST);

    if (TERM_NB < 1 || TERM_NB > TERM_NB_MAX) begin : g_chk_nb
        $fatal(1, "arith_mult_cst_csd: TERM_NB=%0d outside 1..%0d", TERM_NB, TERM_NB_MAX);
    end
    if (ADD_PIPE_PERIOD < 1) begin : g_chk_period
        $fatal(1, "arith_mult_cst_csd: ADD_PIPE_PERIOD=%0d must be >= 1", ADD_PIPE_PERIOD);
    end
    if (!pow_ok()) begin : g_chk_pow
        $fatal(1, "arith_mult_cst_csd: TERM_POW=%0h exceeds CST_W=%0d", TERM_POW, CST_W);
    end
    if (CST_SUM != CST_EXT || CST_SUM <= 0) begin : g_chk_cst
        $fatal(1, "arith_mult_cst_csd: terms do not give CST=%0d (CST_W=%0d TERM_POW=%0h TERM_SGN=%0b)",
               CST, CST_W, TERM_POW, TERM_SGN);
    end

    logic [IN_W-1:0]              a_op;
    logic [TERM_NB-1:0][Z_W-1:0]  lvl0;
    logic [TERM_NB-1:0][Z_W-1:0]  lvl1;
    logic [TERM_NB-1:0][Z_W-1:0]  lvl2;
    logic [TERM_NB-1:0][Z_W-1:0]  lvl3;
    logic [Z_W-1:0]               z_q;
    logic                         unused_tree;

    if (IN_PIPE) begin : g_in_pipe
        arith_mult_cst_csd_dreg #(.W(IN_W)) u_in_reg (
            .clk     (clk),
            .s_rst_n (s_rst_n),
            .d_i     (a),
            .q_o     (a_op)
        );
    end else begin : g_in_comb
        assign a_op = a;
    end

    // Shifted operand per term; subtracted terms enter the tree already negated.
    for (genvar i = 0; i < TERM_NB; i++) begin : g_term
        logic [Z_W-1:0] shifted;
        assign shifted = Z_W'(a_op) << TERM_POW[i];
        if (TERM_SGN[i]) begin : g_neg
            assign lvl0[i] = Z_W'(0) - shifted;
        end else begin : g_pos
            assign lvl0[i] = shifted;
        end
    end

    // At most three levels for eight terms; unused levels are wires.
    if (LVL_NB >= 1) begin : g_lvl1
        arith_mult_cst_csd_lvl #(.Z_W(Z_W), .N(TERM_NB), .N_IN(nodes(0)), .REG(lvl_reg(1))) u_lvl (
            .clk     (clk),
            .s_rst_n (s_rst_n),
            .op_i    (lvl0),
            .sum_o   (lvl1)
        );
    end else begin : g_thru1
        assign lvl1 = lvl0;
    end

    if (LVL_NB >= 2) begin : g_lvl2
        arith_mult_cst_csd_lvl #(.Z_W(Z_W), .N(TERM_NB), .N_IN(nodes(1)), .REG(lvl_reg(2))) u_lvl (
            .clk     (clk),
            .s_rst_n (s_rst_n),
            .op_i    (lvl1),
            .sum_o   (lvl2)
        );
    end else begin : g_thru2
        assign lvl2 = lvl1;
    end

    if (LVL_NB >= 3) begin : g_lvl3
        arith_mult_cst_csd_lvl #(.Z_W(Z_W), .N(TERM_NB), .N_IN(nodes(2)), .REG(lvl_reg(3))) u_lvl (
            .clk     (clk),
            .s_rst_n (s_rst_n),
            .op_i    (lvl2),
            .sum_o   (lvl3)
        );
    end else begin : g_thru3
        assign lvl3 = lvl2;
    end

    assign unused_tree = ^(lvl3 >> Z_W);

    // A single term has no adder level, so it still gets one output register.
    if (LVL_NB == 0) begin : g_single
        arith_mult_cst_csd_dreg #(.W(Z_W)) u_out_reg (
            .clk     (clk),
            .s_rst_n (s_rst_n),
            .d_i     (lvl3[0]),
            .q_o     (z_q)
        );
    end else begin : g_tree_out
        assign z_q = lvl3[0];
    end

    assign z = z_q;

    logic [LAT-1:0] avail_q;

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) avail_q <= '0;
        else          avail_q <= LAT'({avail_q, in_avail});
    end

    assign out_avail = avail_q[LAT-1];

    if (SIDE_W > 0) begin : g_side
        logic [SIDE_WI-1:0] side_q [LAT];

        if (RST_SIDE != 2'b00) begin : g_side_rst
            localparam logic [SIDE_WI-1:0] SIDE_RST = {SIDE_WI{RST_SIDE[1] & ~RST_SIDE[0]}};

            always_ff @(posedge clk or negedge s_rst_n) begin
                if (!s_rst_n) begin
                    for (int k = 0; k < int'(LAT); k++) side_q[k] <= SIDE_RST;
                end else begin
                    side_q[0] <= in_side;
                    for (int k = 1; k < int'(LAT); k++) side_q[k] <= side_q[k-1];
                end
            end
        end else begin : g_side_nrst
            always_ff @(posedge clk) begin
                side_q[0] <= in_side;
                for (int k = 1; k < int'(LAT); k++) side_q[k] <= side_q[k-1];
            end
        end

        assign out_side = side_q[LAT-1];
    end else begin : g_no_side
        logic unused_side;
        assign unused_side = ^in_side;
        assign out_side    = '0;
    end
endmodule

// File: doc/arith_mult_cst_csd.md
Name: arith_mult_cst_csd

Overview:
- Pipelined multiplier by a compile-time constant given in signed-power-of-two (CSD / generalised Solinas) form: CST = sum over i of TERM_SGN[i]*2**TERM_POW[i].
- Covers Solinas2/Solinas3 and any sparse constant with up to TERM_NB_MAX terms.
- Uses a registered adder tree with a configurable register period, plus avail/side propagation.
- Sits in the NTT/modular-reduction datapath wherever a product by a sparse modulus-related constant is needed.

Parameters:
- IN_W, 64, input operand width.
- CST_W, 64, constant width; z width is IN_W+CST_W.
- TERM_NB, 3, number of signed power-of-two terms (1..TERM_NB_MAX=8).
- TERM_POW, {64,32,0}, [TERM_NB-1:0][31:0] exponents; each < CST_W+1.
- TERM_SGN, 3'b010, [TERM_NB-1:0] sign per term (1 = subtract).
- CST, 2**64-2**32+1, [CST_W-1:0] reference value, checked against the terms.
- IN_PIPE, 1'b1, register the input operand.
- ADD_PIPE_PERIOD, 1, insert a register after every ADD_PIPE_PERIOD adder-tree levels (>=1).
- SIDE_W, 0, side data width (0 = unused).
- RST_SIDE, 2'b00, [0] resets side to 0; [1] resets side to 1.

Ports:
- clk  in  1  clock
- s_rst_n  in  1  asynchronous, active-low reset
- a  in  IN_W  operand
- in_avail  in  1  operand valid
- in_side  in  SIDE_W  side data accompanying a
- z  out  IN_W+CST_W  a*CST
- out_avail  out  1  z valid
- out_side  out  SIDE_W  side data aligned with z

Behaviour:
- Elaboration check: sum of TERM_SGN/TERM_POW terms, evaluated exactly, must equal CST and be >0. Otherwise $fatal printing CST, CST_W and the terms. Also $fatal if TERM_NB is outside 1..8, ADD_PIPE_PERIOD<1, or any TERM_POW>CST_W.
- Operand generation: term i = a zero-extended to IN_W+CST_W and shifted left by TERM_POW[i]. It is negated (two's complement) when TERM_SGN[i]=1.
- Arithmetic is modulo 2**(IN_W+CST_W). Intermediate wrap is allowed; the final result is exact because a*CST < 2**(IN_W+CST_W).
- Adder tree:
  - Binary tree of TERM_NB operands, with L = clog2(TERM_NB) levels.
  - An odd operand passes through the level unchanged, but is registered alongside the others.
  - Level l (1..L) is registered when l % ADD_PIPE_PERIOD == 0 or l == L.
  - TERM_NB=1: a single output register.
- Latency: LAT = IN_PIPE + max(1, ceil(L/ADD_PIPE_PERIOD)) cycles from in_avail to out_avail. Fully pipelined, one result per cycle, no back-pressure.
- avail/side use a delay line matched to LAT.
  - On reset, all avail bits go to 0 immediately (asynchronous).
  - Side bits reset per RST_SIDE; if RST_SIDE=0 they are not reset.
- Data registers are not reset (see Optional Feature).
- z is don't-care while out_avail=0; the bench compares z only when out_avail=1.
- Reset mid-operation: all in-flight avail is dropped. After s_rst_n deasserts, out_avail stays 0 until LAT cycles after the next in_avail.
- Back-to-back and bubbled in_avail patterns are reproduced exactly at the output, shifted by LAT.
- a=0 gives z=0. The maximum a gives exactly (2**IN_W-1)*CST with no overflow.

Optional Feature:
- Macro ARITH_MULT_CST_CSD_DATA_RST_EN.
- Defined: every data pipeline register (input register, tree registers, z) resets asynchronously to 0. z reads 0 from reset until the first valid result arrives.
- Undefined: data registers have no reset, for area/timing; z is X/don't-care after reset until the first valid result.
- avail/side behaviour is identical in both cases.

Test Plan:
- Goldilocks setup: IN_W=64, CST_W=64, terms {+2^64, -2^32, +2^0}, IN_PIPE=1, P=1. Drive a=2^64-1 -> z=(2^64-1)*(2^64-2^32+1) exactly, with out_avail 3 cycles after in_avail (L=2, LAT=3).
- Small Solinas3 setup: IN_W=8, CST_W=8, terms {+2^8, -2^4, -2^2, +2^0} (CST=237), P=2, IN_PIPE=0. Drive a=255 -> z=60435; a=0 -> z=0. LAT=1.
- TERM_NB=5 with P=1, IN_PIPE=1 -> LAT=4. Drive 100 random a with random in_avail gaps -> out_avail pattern equals in_avail delayed by 4; every z equals the model; out_side equals in_side delayed by 4 (SIDE_W=4).
- Reset asserted asynchronously mid-stream with 3 results in flight -> out_avail=0 immediately. With RST_SIDE=2'b10, out_side=4'hF. No stale result appears after release.
- Build with ARITH_MULT_CST_CSD_DATA_RST_EN -> z=0 after reset until the first result. Mismatched CST parameter (237 vs terms summing to 241) -> elaboration $fatal.
